// File: rtl/grt_access_arbiter.sv
// Serialises alloc and dealloc operations into the global resource table, one at a time.
// Dealloc requests are buffered in a small FWFT FIFO; alloc vs dealloc is arbitrated round-robin.
module grt_access_arbiter #(
  parameter int unsigned CU_ID_WIDTH             = 3,
  parameter int unsigned WG_ID_WIDTH             = 10,
  parameter int unsigned DEALLOC_FIFO_DEPTH      = 4,
  parameter int unsigned DEALLOC_FIFO_ADDR_WIDTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alloc_req_valid,
  input  logic [WG_ID_WIDTH-1:0] alloc_req_wg_id,
  output logic                   alloc_req_ack,
  input  logic                   dealloc_req_valid,
  input  logic [CU_ID_WIDTH-1:0] dealloc_req_cu_id,
  input  logic [WG_ID_WIDTH-1:0] dealloc_req_wg_id,
  output logic                   dealloc_req_ready,
  output logic                   dealloc_done,
  output logic [WG_ID_WIDTH-1:0] dealloc_done_wg_id,
  output logic                   grt_alloc_valid,
  output logic                   grt_dealloc_valid,
  output logic [CU_ID_WIDTH-1:0] grt_dealloc_cu_id,
  output logic [WG_ID_WIDTH-1:0] grt_dealloc_wg_id,
  input  logic                   grt_wg_alloc_done,
  input  logic [WG_ID_WIDTH-1:0] grt_wg_alloc_wgid,
  input  logic                   grt_wg_dealloc_done,
  input  logic [WG_ID_WIDTH-1:0] grt_wg_dealloc_wgid,
  output logic                   busy,
  output logic                   err_unexpected_done
);

  localparam int unsigned AW = DEALLOC_FIFO_ADDR_WIDTH;
  localparam logic [AW:0]   CountFull = (AW + 1)'(DEALLOC_FIFO_DEPTH);
  localparam logic [AW:0]   CountOne  = (AW + 1)'(1);
  localparam logic [AW-1:0] PtrLast   = AW'(DEALLOC_FIFO_DEPTH - 1);
  localparam logic [AW-1:0] PtrOne    = AW'(1);

  typedef enum logic [1:0] {
    StIdle,
    StAllocWait,
    StDeallocWait
  } state_e;

  state_e state_q, state_d;

  // FIFO storage and bookkeeping
  logic [CU_ID_WIDTH-1:0] fifo_cu_q [DEALLOC_FIFO_DEPTH];
  logic [WG_ID_WIDTH-1:0] fifo_wg_q [DEALLOC_FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr_q, rd_ptr_q;
  logic [AW:0]            count_q, count_d;
  logic                   fifo_empty;
  logic                   push, pop;

  // Arbitration and operation tracking
  logic                   last_dealloc_q, last_dealloc_d;
  logic [WG_ID_WIDTH-1:0] alloc_wg_q;
  logic                   alloc_elig;
  logic                   grant_alloc, grant_dealloc;
  logic                   ack_q, ack_d;
  logic                   done_q, done_d;
  logic [WG_ID_WIDTH-1:0] done_wg_q;
  logic                   galloc_q, gdealloc_q;
  logic [CU_ID_WIDTH-1:0] gcu_q;
  logic [WG_ID_WIDTH-1:0] gwg_q;
  logic                   ready_q;
  logic                   busy_q;
  logic                   err_q, err_d;

  assign fifo_empty = (count_q == '0);
  assign push       = dealloc_req_valid && ready_q;
  assign pop        = grant_dealloc;
  // An alloc is masked during its own ack cycle so the held request is not granted twice.
  assign alloc_elig = alloc_req_valid && !ack_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CountOne;
    end else if (!push && pop) begin
      count_d = count_q - CountOne;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_dealloc_d = last_dealloc_q;
    grant_alloc    = 1'b0;
    grant_dealloc  = 1'b0;
    ack_d          = 1'b0;
    done_d         = 1'b0;
    err_d          = err_q;
    unique case (state_q)
      StIdle: begin
        if (grt_wg_alloc_done || grt_wg_dealloc_done) begin
          err_d = 1'b1;
        end
        // On a tie the side that did not win last time gets the grant.
        if (alloc_elig && (fifo_empty || last_dealloc_q)) begin
          grant_alloc    = 1'b1;
          last_dealloc_d = 1'b0;
          state_d        = StAllocWait;
        end else if (!fifo_empty) begin
          grant_dealloc  = 1'b1;
          last_dealloc_d = 1'b1;
          state_d        = StDeallocWait;
        end
      end
      StAllocWait: begin
        if (grt_wg_alloc_done && (grt_wg_alloc_wgid == alloc_wg_q)) begin
          ack_d   = 1'b1;
          state_d = StIdle;
        end else if (grt_wg_alloc_done) begin
          err_d = 1'b1;
        end
        if (grt_wg_dealloc_done) begin
          err_d = 1'b1;
        end
      end
      StDeallocWait: begin
        if (grt_wg_dealloc_done && (grt_wg_dealloc_wgid == gwg_q)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end else if (grt_wg_dealloc_done) begin
          err_d = 1'b1;
        end
        if (grt_wg_alloc_done) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Payload storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_cu_q[wr_ptr_q] <= dealloc_req_cu_id;
      fifo_wg_q[wr_ptr_q] <= dealloc_req_wg_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      last_dealloc_q <= 1'b1;
      alloc_wg_q     <= '0;
      ack_q          <= 1'b0;
      done_q         <= 1'b0;
      done_wg_q      <= '0;
      galloc_q       <= 1'b0;
      gdealloc_q     <= 1'b0;
      gcu_q          <= '0;
      gwg_q          <= '0;
      ready_q        <= 1'b0;
      busy_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      last_dealloc_q <= last_dealloc_d;
      ack_q          <= ack_d;
      done_q         <= done_d;
      galloc_q       <= grant_alloc;
      gdealloc_q     <= grant_dealloc;
      ready_q        <= (count_d != CountFull);
      busy_q         <= (state_d != StIdle);
      err_q          <= err_d;
      if (push) begin
        wr_ptr_q <= (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrOne;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrOne;
        gcu_q    <= fifo_cu_q[rd_ptr_q];
        gwg_q    <= fifo_wg_q[rd_ptr_q];
      end
      if (grant_alloc) begin
        alloc_wg_q <= alloc_req_wg_id;
      end
      if (done_d) begin
        done_wg_q <= gwg_q;
      end
    end
  end

  assign alloc_req_ack       = ack_q;
  assign dealloc_req_ready   = ready_q;
  assign dealloc_done        = done_q;
  assign dealloc_done_wg_id  = done_wg_q;
  assign grt_alloc_valid     = galloc_q;
  assign grt_dealloc_valid   = gdealloc_q;
  assign grt_dealloc_cu_id   = gcu_q;
  assign grt_dealloc_wg_id   = gwg_q;
  assign busy                = busy_q;
  assign err_unexpected_done = err_q;

endmodule

// File: tb/tb_grt_access_arbiter.sv
// Bench for grt_access_arbiter: directed scenarios plus random traffic, checked every cycle
// against a queue-based transaction model of the arbiter.
module tb_grt_access_arbiter;

  localparam int unsigned CW    = 3;
  localparam int unsigned WW    = 10;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          a_valid;
  logic [WW-1:0] a_wg;
  logic          alloc_req_ack;
  logic          d_valid;
  logic [CW-1:0] d_cu;
  logic [WW-1:0] d_wg;
  logic          dealloc_req_ready;
  logic          dealloc_done;
  logic [WW-1:0] dealloc_done_wg_id;
  logic          grt_alloc_valid;
  logic          grt_dealloc_valid;
  logic [CW-1:0] grt_dealloc_cu_id;
  logic [WW-1:0] grt_dealloc_wg_id;
  logic          ad, dd;
  logic [WW-1:0] awg, dwg;
  logic          busy;
  logic          err_unexpected_done;

  grt_access_arbiter #(
    .CU_ID_WIDTH            (CW),
    .WG_ID_WIDTH            (WW),
    .DEALLOC_FIFO_DEPTH     (DEPTH),
    .DEALLOC_FIFO_ADDR_WIDTH(2)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .alloc_req_valid    (a_valid),
    .alloc_req_wg_id    (a_wg),
    .alloc_req_ack      (alloc_req_ack),
    .dealloc_req_valid  (d_valid),
    .dealloc_req_cu_id  (d_cu),
    .dealloc_req_wg_id  (d_wg),
    .dealloc_req_ready  (dealloc_req_ready),
    .dealloc_done       (dealloc_done),
    .dealloc_done_wg_id (dealloc_done_wg_id),
    .grt_alloc_valid    (grt_alloc_valid),
    .grt_dealloc_valid  (grt_dealloc_valid),
    .grt_dealloc_cu_id  (grt_dealloc_cu_id),
    .grt_dealloc_wg_id  (grt_dealloc_wg_id),
    .grt_wg_alloc_done  (ad),
    .grt_wg_alloc_wgid  (awg),
    .grt_wg_dealloc_done(dd),
    .grt_wg_dealloc_wgid(dwg),
    .busy               (busy),
    .err_unexpected_done(err_unexpected_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: outstanding operation (0 none, 1 alloc, 2 dealloc) and a queue of deallocs.
  int                  m_op;
  logic [WW-1:0]       m_wg;
  bit                  m_last_d;
  bit                  m_pushed;
  logic [CW+WW-1:0]    m_q[$];
  logic                e_av, e_dv, e_ack, e_done, e_ready, e_busy, e_err;
  logic [WW-1:0]       e_done_wg, e_dwg;
  logic [CW-1:0]       e_dcu;

  // Stimulus agents
  logic [CW+WW-1:0]    src_q[$];
  bit                  auto_grt, auto_alloc, drop_next;
  int                  grt_cnt, alloc_pct, bad_pct;
  bit                  rec_grant, rec_done;
  bit                  grant_log[$];
  logic [WW-1:0]       done_log[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    logic             cur_ack;
    int               op_now;
    bit               pushed, ea, ed;
    logic [CW+WW-1:0] h;
    m_pushed = 0;
    if (rst) begin
      m_q.delete();
      m_op = 0; m_last_d = 1;
      e_av = 0; e_dv = 0; e_ack = 0; e_done = 0; e_ready = 0; e_busy = 0; e_err = 0;
      e_done_wg = '0; e_dwg = '0; e_dcu = '0;
      return;
    end
    cur_ack = e_ack;
    op_now  = m_op;
    pushed  = d_valid && e_ready;
    e_av = 0; e_dv = 0; e_ack = 0; e_done = 0;
    case (op_now)
      0: if (ad || dd) e_err = 1;
      1: begin
        if (ad && awg == m_wg) begin e_ack = 1; m_op = 0; end
        else if (ad) e_err = 1;
        if (dd) e_err = 1;
      end
      default: begin
        if (dd && dwg == e_dwg) begin e_done = 1; e_done_wg = e_dwg; m_op = 0; end
        else if (dd) e_err = 1;
        if (ad) e_err = 1;
      end
    endcase
    if (op_now == 0) begin
      ea = a_valid && !cur_ack;
      ed = m_q.size() > 0;
      if (ea && (!ed || m_last_d)) begin
        m_op = 1; m_wg = a_wg; e_av = 1; m_last_d = 0;
      end else if (ed) begin
        h = m_q.pop_front();
        {e_dcu, e_dwg} = h;
        m_op = 2; e_dv = 1; m_last_d = 1;
      end
    end
    if (pushed) m_q.push_back({d_cu, d_wg});
    m_pushed = pushed;
    e_ready  = m_q.size() < DEPTH;
    e_busy   = m_op != 0;
  endtask

  task automatic check_all();
    chk("alloc_req_ack",       32'(alloc_req_ack),       32'(e_ack));
    chk("dealloc_req_ready",   32'(dealloc_req_ready),   32'(e_ready));
    chk("dealloc_done",        32'(dealloc_done),        32'(e_done));
    chk("dealloc_done_wg_id",  32'(dealloc_done_wg_id),  32'(e_done_wg));
    chk("grt_alloc_valid",     32'(grt_alloc_valid),     32'(e_av));
    chk("grt_dealloc_valid",   32'(grt_dealloc_valid),   32'(e_dv));
    chk("grt_dealloc_cu_id",   32'(grt_dealloc_cu_id),   32'(e_dcu));
    chk("grt_dealloc_wg_id",   32'(grt_dealloc_wg_id),   32'(e_dwg));
    chk("busy",                32'(busy),                32'(e_busy));
    chk("err_unexpected_done", 32'(err_unexpected_done), 32'(e_err));
    chk("valid_exclusive",     32'(grt_alloc_valid & grt_dealloc_valid), 32'(0));
  endtask

  task automatic grt_drive();
    if (m_op != 0 && !e_av && !e_dv) begin
      if (grt_cnt == 0) begin
        if (m_op == 1) begin ad = 1; awg = m_wg; end
        else begin dd = 1; dwg = e_dwg; end
        grt_cnt = $urandom_range(0, 3);
      end else begin
        grt_cnt--;
      end
    end else if (m_op == 0 && $urandom_range(0, 99) < bad_pct) begin
      if ($urandom_range(0, 1) == 1) begin ad = 1; awg = WW'($urandom); end
      else begin dd = 1; dwg = WW'($urandom); end
    end
  endtask

  task automatic alloc_drive();
    if (drop_next) begin a_valid = 0; drop_next = 0; end
    // Requester holds its request through the ack cycle and drops it afterwards.
    if (a_valid && e_ack) drop_next = 1;
    else if (!a_valid && $urandom_range(0, 99) < alloc_pct) begin
      a_valid = 1; a_wg = WW'($urandom);
    end
  endtask

  task automatic tick();
    if (!d_valid && src_q.size() > 0) begin
      {d_cu, d_wg} = src_q.pop_front();
      d_valid = 1;
    end
    if (auto_grt) grt_drive();
    if (auto_alloc) alloc_drive();
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
    if (rec_grant) begin
      if (grt_alloc_valid) grant_log.push_back(1'b1);
      if (grt_dealloc_valid) grant_log.push_back(1'b0);
    end
    if (rec_done && dealloc_done) done_log.push_back(dealloc_done_wg_id);
    if (m_pushed) d_valid = 0;
    ad = 0; dd = 0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    alloc_pct = 0; auto_alloc = 1; auto_grt = 1;
    while ((m_op != 0 || a_valid || d_valid || src_q.size() > 0 || m_q.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    chk(tag, 32'(n < 300), 32'(1));
    auto_alloc = 0; auto_grt = 0; drop_next = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int       exp_wg[5] = '{1, 4, 7, 3, 2};
    logic [3:0] pat;
    rst = 1; a_valid = 0; a_wg = '0; d_valid = 0; d_cu = '0; d_wg = '0;
    ad = 0; dd = 0; awg = '0; dwg = '0;
    auto_grt = 0; auto_alloc = 0; drop_next = 0; grt_cnt = 0; alloc_pct = 0; bad_pct = 0;
    rec_grant = 0; rec_done = 0;
    e_ack = 0; e_ready = 0;

    // Reset held two cycles with an alloc already pending
    a_valid = 1; a_wg = 9;
    tick(); tick();
    chk("rst_ready_low", 32'(dealloc_req_ready), 32'(0));
    rst = 0;
    tick();
    chk("rst_first_grant_alloc", 32'(grt_alloc_valid), 32'(1));
    chk("rst_ready_high", 32'(dealloc_req_ready), 32'(1));
    tick();
    ad = 1; awg = 9; tick();
    tick(); a_valid = 0; tick();

    // Single alloc, GRT done three cycles after issue
    a_valid = 1; a_wg = 5; tick();
    chk("single_issue", 32'(grt_alloc_valid), 32'(1));
    tick(); tick(); tick();
    ad = 1; awg = 5; tick();
    chk("single_ack", 32'(alloc_req_ack), 32'(1));
    tick();
    chk("single_no_regrant", 32'(grt_alloc_valid), 32'(0));
    a_valid = 0; tick();
    chk("single_idle", 32'(busy), 32'(0));

    // FIFO fill while an alloc is outstanding
    a_valid = 1; a_wg = 20; tick();
    src_q.push_back({3'd4, 10'd1}); src_q.push_back({3'd0, 10'd4});
    src_q.push_back({3'd2, 10'd7}); src_q.push_back({3'd5, 10'd3});
    src_q.push_back({3'd6, 10'd2});
    done_log.delete(); rec_done = 1;
    for (int i = 0; i < 8; i++) tick();
    chk("fifo_full_ready", 32'(dealloc_req_ready), 32'(0));
    chk("fifo_full_busy", 32'(busy), 32'(1));
    ad = 1; awg = 20; tick();
    tick(); a_valid = 0;
    drain("fifo_drain");
    rec_done = 0;
    for (int i = 0; i < 5; i++)
      chk($sformatf("fifo_order%0d", i),
          (i < done_log.size()) ? 32'(done_log[i]) : 32'hffff_ffff, 32'(exp_wg[i]));

    // Alloc and dealloc pending continuously
    grant_log.delete(); rec_grant = 1;
    a_valid = 1; a_wg = 30; auto_alloc = 1; alloc_pct = 100;
    src_q.push_back({3'd1, 10'd40}); src_q.push_back({3'd2, 10'd41});
    src_q.push_back({3'd3, 10'd42});
    for (int i = 0; i < 4; i++) tick();
    auto_grt = 1;
    for (int i = 0; i < 60 && grant_log.size() < 4; i++) tick();
    rec_grant = 0;
    chk("tie_grant_count", 32'(grant_log.size() >= 4), 32'(1));
    pat = '0;
    if (grant_log.size() >= 4) for (int i = 0; i < 4; i++) pat[3-i] = grant_log[i];
    chk("tie_pattern", 32'(pat), 32'(4'b1010));
    drain("tie_drain");

    // Wrong-type done while waiting on an alloc
    a_valid = 1; a_wg = 3; tick();
    dd = 1; dwg = 7; tick();
    chk("unexp_err", 32'(err_unexpected_done), 32'(1));
    chk("unexp_still_busy", 32'(busy), 32'(1));
    tick();
    ad = 1; awg = 3; tick();
    chk("unexp_later_ack", 32'(alloc_req_ack), 32'(1));
    tick(); a_valid = 0; tick();

    // Reset during a dealloc wait with two entries queued
    src_q.push_back({3'd1, 10'd11}); src_q.push_back({3'd2, 10'd12});
    src_q.push_back({3'd3, 10'd13});
    tick(); tick(); tick();
    chk("mid_busy", 32'(busy), 32'(1));
    chk("mid_queued", 32'(m_q.size()), 32'(2));
    rst = 1; tick(); rst = 0; tick();
    chk("mid_idle", 32'(busy), 32'(0));
    chk("mid_err_clear", 32'(err_unexpected_done), 32'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_done", 32'(dealloc_done), 32'(0));
      chk("mid_no_issue", 32'(grt_dealloc_valid), 32'(0));
    end

    // Random traffic with occasional stray dones
    auto_alloc = 1; alloc_pct = 30; auto_grt = 1; bad_pct = 2;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 3) == 0 && src_q.size() < 2)
        src_q.push_back({CW'($urandom), WW'($urandom)});
      tick();
    end
    bad_pct = 0;
    drain("rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/grt_access_arbiter.md
Name: grt_access_arbiter

Overview:
- Sequences all accesses to global_resource_table (GRT); the GRT handles exactly one alloc or dealloc operation at a time.
- Sits between the dispatcher allocator (alloc requests), the GPU interface (WG-completion dealloc requests) and the GRT.
- Buffers dealloc requests in a small FIFO, arbitrates alloc vs dealloc round-robin, and issues one single-cycle valid pulse per operation.
- Waits for the matching GRT done (WG id checked) before issuing the next operation, then reports completion to the requester.

Parameters:
- CU_ID_WIDTH, 3, CU id width.
- WG_ID_WIDTH, 10, workgroup id width.
- DEALLOC_FIFO_DEPTH, 4, dealloc request buffer entries.
- DEALLOC_FIFO_ADDR_WIDTH, 2, log2(DEALLOC_FIFO_DEPTH).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- alloc_req_valid  in  1  allocator has a WG to commit. The alloc payload goes directly to the GRT and is held stable until alloc_req_ack.
- alloc_req_wg_id  in  WG_ID_WIDTH  WG id of the pending alloc, used for done matching.
- alloc_req_ack  out  1  one-cycle pulse: alloc completed in the GRT.
- dealloc_req_valid  in  1  dealloc request.
- dealloc_req_cu_id  in  CU_ID_WIDTH  CU of the finished WG.
- dealloc_req_wg_id  in  WG_ID_WIDTH  id of the finished WG.
- dealloc_req_ready  out  1  FIFO not full.
- dealloc_done  out  1  one-cycle pulse: dealloc completed.
- dealloc_done_wg_id  out  WG_ID_WIDTH  WG id of the completed dealloc.
- grt_alloc_valid  out  1  drives GRT dis_controller_wg_alloc_valid.
- grt_dealloc_valid  out  1  drives GRT dis_controller_wg_dealloc_valid.
- grt_dealloc_cu_id  out  CU_ID_WIDTH  drives GRT gpu_interface_cu_id.
- grt_dealloc_wg_id  out  WG_ID_WIDTH  drives GRT gpu_interface_wg_id.
- grt_wg_alloc_done  in  1  from GRT.
- grt_wg_alloc_wgid  in  WG_ID_WIDTH  from GRT.
- grt_wg_dealloc_done  in  1  from GRT.
- grt_wg_dealloc_wgid  in  WG_ID_WIDTH  from GRT.
- busy  out  1  state != IDLE.
- err_unexpected_done  out  1  sticky error flag.

Behaviour:
- Reset: all outputs are registered and reset to 0. FIFO is emptied, state goes to IDLE, last_grant = DEALLOC (so alloc wins the first tie).
- Reset mid-operation abandons the in-flight op. No ack or done is generated; the GRT is reset together with this block.
- FIFO push: dealloc_req_valid && dealloc_req_ready. dealloc_req_ready = !full; it does not look ahead to a same-cycle pop. Requests presented while full are not accepted and must be held by the source.
- FIFO is first-word-fall-through with a wrap-around pointer and a count of 0..DEPTH. Push and pop in the same cycle are both performed, count unchanged.
- alloc eligibility: alloc_req_valid && !alloc_req_ack. The request is masked during its ack cycle so it is never re-granted.
- FSM states: IDLE, ALLOC_WAIT, DEALLOC_WAIT.
- IDLE, nothing eligible: stay in IDLE, all valids low.
- IDLE, only alloc eligible: go to ALLOC_WAIT, latch alloc_req_wg_id, grt_alloc_valid = 1 for exactly the next cycle.
- IDLE, only FIFO non-empty: pop the head into grt_dealloc_cu_id/wg_id (held until done), go to DEALLOC_WAIT, grt_dealloc_valid = 1 for exactly the next cycle.
- IDLE, both eligible: grant the opposite of last_grant, then update last_grant.
- ALLOC_WAIT: on grt_wg_alloc_done with grt_wg_alloc_wgid == latched id:
  - alloc_req_ack = 1 next cycle;
  - state goes to IDLE, and a new grant may be decided in that same cycle.
- DEALLOC_WAIT: on grt_wg_dealloc_done with matching wgid:
  - dealloc_done = 1 and dealloc_done_wg_id = id next cycle;
  - state goes to IDLE.
- No timeout; a wait state is held indefinitely.
- Latency: request seen in IDLE at cycle t gives GRT valid at t+1. GRT done at cycle d gives ack/done at d+1. Best-case back-to-back issue interval is done + 2 cycles.
- err_unexpected_done is set (sticky until rst), and the event is otherwise ignored, on any of:
  - any done while IDLE;
  - the wrong type of done for the current state;
  - a wgid mismatch.
- Only one valid output is ever high at a time, and never while busy except in the issue cycle.

Test Plan:
- Reset:
  - Stimulus: rst high 2 cycles with alloc_req_valid = 1.
  - Required: all outputs 0, dealloc_req_ready = 1 after rst falls.
  - Required: first grant is alloc, with grt_alloc_valid at exactly 1 cycle after the first IDLE cycle.
- Single alloc:
  - Stimulus: alloc wg 5 requested; the GRT model returns alloc done wgid 5 after 3 cycles.
  - Required: one grt_alloc_valid pulse, alloc_req_ack one cycle after done, no re-grant of wg 5.
- FIFO full:
  - Stimulus: 5 back-to-back dealloc requests (cu 4/wg 1, cu 0/wg 4, ...) while an alloc is in flight.
  - Required: dealloc_req_ready drops after 4 accepted requests.
  - Required: deallocs issue in FIFO order, each dealloc_done carrying the matching wg id.
- Tie:
  - Stimulus: alloc and dealloc pending continuously.
  - Required: grants alternate A, D, A, D.
- Unexpected done:
  - Stimulus: grt_wg_dealloc_done with wgid 7 while in ALLOC_WAIT for wg 3.
  - Required: err_unexpected_done = 1, state unchanged, later correct alloc done still acked.
- Mid-operation reset:
  - Stimulus: rst asserted in DEALLOC_WAIT with 2 FIFO entries.
  - Required: FIFO empty, IDLE, no dealloc_done pulse.
